uart_tx_peripheral: RTL and testbench
=====================================

// Module: uart_tx_peripheral
// PURPOSE
//  Memory-mapped UART transmitter on the core's data bus, next to the mtime/mtimecmp/LED registers.
//  Consumes core stores to its DATA register, buffers bytes in a FIFO and serialises them 8N1 on uart_tx.
//  Returns registered read data one cycle after the address, matching block-RAM read timing; top muxes it on read_hit.
// PARAMETERS
//  BASE_ADDRESS  32'h80000014  DATA register word address; STATUS is BASE_ADDRESS+4
//  CLKS_PER_BIT  208           clk24 cycles per bit (24 MHz / 115200); legal range 2..65535
//  FIFO_DEPTH    8             byte FIFO entries; power of two, 2..256
// PORTS
//  clk24                input   1   system clock (24 MHz)
//  reset                input   1   asynchronous, active-high reset
//  memory_address       input   32  core data address, byte granular
//  memory_write_value   input   32  store data, already lane-shifted to byte position
//  memory_write_sections input  3   byte lanes: [0]=7:0, [1]=15:8, [2]=31:16; 0 = no store
//  read_value           output  32  registered read data for the previous cycle's address
//  read_hit             output  1   registered; 1 when previous cycle's address matched DATA or STATUS
//  uart_tx              output  1   serial line, idle high
// BEHAVIOUR
//  Reset (async assert, sync release): FIFO empty, count=0, overflow=0, FSM IDLE, uart_tx=1, read_value=0, read_hit=0.
//  Decode on memory_address[31:2] vs BASE_ADDRESS[31:2] (DATA) and +1 (STATUS); [1:0] ignored.
//  A store is memory_write_sections!=0 for exactly one cycle; each such cycle is one store.
//  Store to DATA with sections[0]=1: push memory_write_value[7:0]; sections without bit 0 ignored.
//  Push accepted when count<FIFO_DEPTH OR a pop happens the same cycle (count unchanged then).
//  Push rejected when full with no pop: byte dropped, overflow<=1 (sticky).
//  Store to STATUS with sections[0]=1 and memory_write_value[3]=1: overflow<=0. Same-cycle set beats clear.
//  Reads have no side effects. Every cycle: read_hit<=match; read_value<=
//   DATA: 32'h0. STATUS: {16'h0, count[7:0], 4'h0, overflow, busy, empty, full}. Other addresses: 32'h0, read_hit=0.
//   busy = FSM!=IDLE. Latency: address at edge N, data valid after edge N+1.
//  FSM (baud counter counts 0..CLKS_PER_BIT-1; bit_idx 0..7):
//   IDLE : uart_tx=1. FIFO non-empty -> pop head into shift reg, -> START, counter=0.
//   START: uart_tx=0 for CLKS_PER_BIT cycles -> DATA, bit_idx=0.
//   DATA : uart_tx=shift[0], LSB first, CLKS_PER_BIT cycles per bit; after bit 7 -> STOP.
//   STOP : uart_tx=1 for CLKS_PER_BIT cycles; then FIFO non-empty -> pop, -> START (no idle gap),
//          else -> IDLE.
//  uart_tx is a registered output (glitch-free); frame = 10*CLKS_PER_BIT cycles exactly.
//  First-byte latency: push at edge N, IDLE sees non-empty at N+1, uart_tx falls after edge N+2.
//  FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo depth; count is separate, 0..FIFO_DEPTH.
//  Reset mid-frame: line returns to 1 immediately, FIFO contents discarded, partial byte lost.
// TESTING  (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless stated)
//  1 Reset -> uart_tx=1, STATUS read = 32'h0000_0002 (empty), read_hit=0 when idle address.
//  2 Store 8'hA5 to DATA -> line: 0,1,0,1,0,0,1,0,1,1, each 4 cycles; fall 2 cycles after store edge.
//  3 Store 5 bytes back-to-back while idle -> first pops at once, 4 buffered, none dropped,
//    overflow=0; 50 contiguous frames-cycles... 5 frames = 200 cycles with no idle gap between.
//  4 Store 6 bytes back-to-back -> 6th dropped, STATUS bit3=1; STATUS write 32'h8 -> bit3=0.
//  5 Store with sections=3'b010 to DATA -> no push, count unchanged; store to BASE+8 -> read_hit=0.
//  6 Assert reset mid DATA bit 3 -> uart_tx=1 same cycle, STATUS=32'h2 after release, no frame resumes.

Source files
------------

// File: rtl/uart_tx_peripheral_if.sv
// Core data-bus port of the UART transmitter peripheral.
// The core is the master and the peripheral is the slave; the serial line is carried here as well.
interface uart_tx_peripheral_if;
  logic [31:0] memory_address;
  logic [31:0] memory_write_value;
  logic [2:0]  memory_write_sections;
  logic [31:0] read_value;
  logic        read_hit;
  logic        uart_tx;

  modport master (
    output memory_address,
    output memory_write_value,
    output memory_write_sections,
    input  read_value,
    input  read_hit,
    input  uart_tx
  );

  modport slave (
    input  memory_address,
    input  memory_write_value,
    input  memory_write_sections,
    output read_value,
    output read_hit,
    output uart_tx
  );
endinterface

// File: rtl/uart_tx_peripheral.sv
// Memory-mapped 8N1 UART transmitter: stores to DATA queue bytes in a FIFO, STATUS reports
// FIFO level, sticky overflow and busy; read data is registered one cycle behind the address.
module uart_tx_peripheral #(
  parameter logic [31:0] BASE_ADDRESS = 32'h8000_0014,
  parameter int unsigned CLKS_PER_BIT = 208,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                 clk24,
  input  logic                 reset,
  uart_tx_peripheral_if.slave  bus
);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [29:0]       DATA_WORD   = BASE_ADDRESS[31:2];
  localparam logic [29:0]       STATUS_WORD = BASE_ADDRESS[31:2] + 30'd1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  state_t            r_state;
  state_t            w_state_next;
  logic [BAUD_W-1:0] r_baud;
  logic [BAUD_W-1:0] w_baud_next;
  logic [2:0]        r_bit_idx;
  logic [2:0]        w_bit_idx_next;
  logic [7:0]        r_shift;
  logic [7:0]        w_shift_next;
  logic              r_tx;
  logic              w_tx_next;
  logic [31:0]       r_read_value;
  logic              r_read_hit;

  logic              w_is_data;
  logic              w_is_status;
  logic              w_push_req;
  logic              w_push_ok;
  logic              w_pop;
  logic              w_clear_ovf;
  logic              w_empty;
  logic              w_full;
  logic              w_busy;
  logic              w_baud_last;
  logic [7:0]        w_head;
  logic [31:0]       w_status_word;

  assign w_is_data     = (bus.memory_address[31:2] == DATA_WORD);
  assign w_is_status   = (bus.memory_address[31:2] == STATUS_WORD);
  assign w_push_req    = w_is_data && bus.memory_write_sections[0];
  assign w_clear_ovf   = w_is_status && bus.memory_write_sections[0] && bus.memory_write_value[3];
  assign w_empty       = (r_count == {CNT_W{1'b0}});
  assign w_full        = (r_count == DEPTH_C);
  // A full FIFO still takes a byte when the transmitter frees a slot in the same cycle.
  assign w_push_ok     = w_push_req && (!w_full || w_pop);
  assign w_busy        = (r_state != S_IDLE);
  assign w_baud_last   = (r_baud == BAUD_LAST);
  assign w_head        = r_mem[r_rd_ptr];
  assign w_status_word = {16'h0000, 8'(r_count), 4'h0, r_overflow, w_busy, w_empty, w_full};

  assign bus.read_value = r_read_value;
  assign bus.read_hit   = r_read_hit;
  assign bus.uart_tx    = r_tx;

  // FIFO storage; contents need no reset because the count gates every read.
  always_ff @(posedge clk24) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= bus.memory_write_value[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= {PTR_W{1'b0}};
      r_rd_ptr   <= {PTR_W{1'b0}};
      r_count    <= {CNT_W{1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push_ok && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push_ok) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (w_push_req && !w_push_ok) begin
        r_overflow <= 1'b1;
      end else if (w_clear_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Registered read port, one cycle behind the address like block RAM.
  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      r_read_value <= 32'h0000_0000;
      r_read_hit   <= 1'b0;
    end else begin
      r_read_hit   <= w_is_data || w_is_status;
      r_read_value <= w_is_status ? w_status_word : 32'h0000_0000;
    end
  end

  // Transmitter next-state logic; STOP hands straight over to START when more bytes wait.
  always_comb begin
    w_state_next   = r_state;
    w_baud_next    = r_baud;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_pop          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_next = w_head;
          w_baud_next  = {BAUD_W{1'b0}};
          w_state_next = S_START;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_START: begin
        if (w_baud_last) begin
          w_baud_next    = {BAUD_W{1'b0}};
          w_bit_idx_next = 3'd0;
          w_state_next   = S_DATA;
        end else begin
          w_baud_next = r_baud + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (w_baud_last) begin
          w_baud_next = {BAUD_W{1'b0}};
          if (r_bit_idx == 3'd7) begin
            w_state_next = S_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
            w_shift_next   = {1'b0, r_shift[7:1]};
          end
        end else begin
          w_baud_next = r_baud + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (w_baud_last) begin
          w_baud_next = {BAUD_W{1'b0}};
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_shift_next = w_head;
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_baud_next = r_baud + BAUD_W'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Line level follows the current state and is registered so the pin never glitches.
  always_comb begin
    w_tx_next = 1'b1;
    case (r_state)
      S_IDLE:  w_tx_next = 1'b1;
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = r_shift[0];
      S_STOP:  w_tx_next = 1'b1;
      default: w_tx_next = 1'b1;
    endcase
  end

  // Transmitter state registers; reset drops the line high straight away.
  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_baud    <= {BAUD_W{1'b0}};
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_baud    <= w_baud_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_tx      <= w_tx_next;
    end
  end
endmodule

// File: tb/tb_uart_tx_peripheral.sv
// Bench for uart_tx_peripheral: directed steps with random bytes, the serial line checked
// against a time-indexed model of the expected 8N1 frame stream.
module tb_uart_tx_peripheral;
  localparam int          CPB    = 4;
  localparam int          DEPTH  = 4;
  localparam int          FRAME  = 10 * CPB;
  localparam logic [31:0] BASE   = 32'h8000_0014;
  localparam logic [31:0] STATUS = BASE + 32'd4;

  logic       clk24 = 1'b0;
  logic       reset;
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic [7:0] exp_q[$];

  uart_tx_peripheral_if bus();

  uart_tx_peripheral #(
    .BASE_ADDRESS (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk24 (clk24),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk24 = ~clk24;

  task automatic tick();
    @(posedge clk24);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] status_word(input int cnt, input logic ovf, input logic busy);
    logic [7:0] c8;
    c8 = 8'(cnt);
    return {16'h0000, c8, 4'h0, ovf, busy, (cnt == 0), (cnt == DEPTH)};
  endfunction

  // Expected line level i cycles after the first start bit of the queued stream.
  function automatic logic line_bit(input int i);
    int         k;
    logic [7:0] b;
    k = (i % FRAME) / CPB;
    b = exp_q[i / FRAME];
    if (k == 0) return 1'b0;
    else if (k == 9) return 1'b1;
    else return b[k-1];
  endfunction

  task automatic store(input logic [31:0] addr, input logic [31:0] val, input logic [2:0] sec);
    bus.memory_address        = addr;
    bus.memory_write_value    = val;
    bus.memory_write_sections = sec;
    tick();
    bus.memory_write_sections = 3'b000;
    bus.memory_address        = 32'h0000_0000;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] val, output logic hit);
    bus.memory_address = addr;
    tick();
    val = bus.read_value;
    hit = bus.read_hit;
    bus.memory_address = 32'h0000_0000;
  endtask

  task automatic check_status(input string tag, input logic [31:0] exp);
    logic [31:0] v;
    logic        h;
    rd(STATUS, v, h);
    chk({tag, " value"}, v, exp);
    chk({tag, " hit"}, {31'h0, h}, 32'h1);
  endtask

  // Back-to-back stores while idle: the shift register plus the FIFO hold DEPTH+1 bytes.
  task automatic burst(input int n, output int start);
    logic [31:0] v;
    exp_q.delete();
    start = 0;
    for (int k = 0; k < n; k++) begin
      v = $urandom;
      store(BASE, v, 3'b001);
      if (k == 0) start = cyc + 2;
      if (k < DEPTH + 1) exp_q.push_back(v[7:0]);
    end
  endtask

  task automatic check_stream(input int start);
    int total;
    total = exp_q.size() * FRAME;
    while (cyc < start) tick();
    while (cyc - start < total) begin
      chk($sformatf("line c%0d", cyc - start), {31'h0, bus.uart_tx}, {31'h0, line_bit(cyc - start)});
      tick();
    end
    chk("line idle after stream", {31'h0, bus.uart_tx}, 32'h1);
  endtask

  task automatic run_round(input int n);
    int start;
    int acc;
    burst(n, start);
    acc = (n < DEPTH + 1) ? n : DEPTH + 1;
    tick();
    check_status($sformatf("status during n=%0d", n), status_word(acc - 1, (n > DEPTH + 1), 1'b1));
    check_stream(start);
    check_status($sformatf("status after n=%0d", n), status_word(0, (n > DEPTH + 1), 1'b0));
    store(STATUS, 32'h0000_0008, 3'b001);
    check_status("status after clear", 32'h0000_0002);
  endtask

  initial begin
    int          start;
    logic [31:0] v;
    logic        h;

    reset                     = 1'b1;
    bus.memory_address        = 32'h0000_0000;
    bus.memory_write_value    = 32'h0000_0000;
    bus.memory_write_sections = 3'b000;
    tick();
    tick();
    chk("reset tx", {31'h0, bus.uart_tx}, 32'h1);
    chk("reset read_value", bus.read_value, 32'h0);
    chk("reset read_hit", {31'h0, bus.read_hit}, 32'h0);
    reset = 1'b0;
    tick();
    rd(32'h0000_0000, v, h);
    chk("idle addr hit", {31'h0, h}, 32'h0);
    check_status("status after reset", 32'h0000_0002);

    // Single byte 0xA5: line falls two edges after the store edge.
    exp_q.delete();
    exp_q.push_back(8'hA5);
    store(BASE, 32'h0000_00A5, 3'b001);
    start = cyc + 2;
    tick();
    chk("latency still idle", {31'h0, bus.uart_tx}, 32'h1);
    check_stream(start);
    check_status("status after A5", 32'h0000_0002);

    run_round(5);
    run_round(6);
    for (int r = 0; r < 3; r++) run_round(int'($urandom_range(1, 8)));

    // A store in the cycle the next byte is taken is accepted even when full; one later is dropped.
    burst(5, start);
    while (cyc < start + FRAME - 2) tick();
    v = $urandom;
    store(BASE, v, 3'b001);
    exp_q.push_back(v[7:0]);
    store(BASE, 32'h0000_00FF, 3'b001);
    check_stream(start);
    check_status("status full+pop", status_word(0, 1'b1, 1'b0));
    store(STATUS, 32'h0000_0008, 3'b001);
    check_status("status clear 2", 32'h0000_0002);

    // Non-pushing stores and address decode.
    store(BASE, 32'h0000_00FF, 3'b010);
    store(BASE, 32'h1234_5600, 3'b100);
    check_status("status lane ignore", 32'h0000_0002);
    store(BASE + 32'd8, 32'h0000_0055, 3'b001);
    rd(BASE + 32'd8, v, h);
    chk("base+8 hit", {31'h0, h}, 32'h0);
    chk("base+8 value", v, 32'h0);
    rd(BASE, v, h);
    chk("data hit", {31'h0, h}, 32'h1);
    chk("data value", v, 32'h0);
    rd(STATUS + 32'd3, v, h);
    chk("status+3 hit", {31'h0, h}, 32'h1);
    chk("status+3 value", v, 32'h0000_0002);
    for (int i = 0; i < 20; i++) begin
      chk("no frame after ignored stores", {31'h0, bus.uart_tx}, 32'h1);
      tick();
    end

    // Reset during data bit 3 of a zero byte with a second byte queued.
    store(BASE, 32'h0000_0000, 3'b001);
    start = cyc + 2;
    store(BASE, 32'h0000_0000, 3'b001);
    while (cyc < start + 4 * CPB + 1) tick();
    chk("bit3 low before reset", {31'h0, bus.uart_tx}, 32'h0);
    reset = 1'b1;
    #1;
    chk("tx high on reset", {31'h0, bus.uart_tx}, 32'h1);
    tick();
    tick();
    reset = 1'b0;
    check_status("status after mid-frame reset", 32'h0000_0002);
    for (int i = 0; i < 3 * FRAME; i++) begin
      chk("no frame resumes", {31'h0, bus.uart_tx}, 32'h1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
